// File: rtl/mem_issue_queue_pkg.sv
// Shared definitions for the memory issue queue.
// Holds the default widths, the "operand ready" label, the first queue tag
// and the memory op encodings.
package mem_issue_queue_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int LABEL_W_DEF = 4;

  // A label of zero means the operand value is already present.
  localparam int LABEL_NONE = 0;

  // Memory broadcasts its results on the CDB starting at this tag.
  localparam logic [3:0] QUE_TAG_BASE = 4'b1100;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } mem_op_e;

endpackage

// File: rtl/mem_issue_queue_entry.sv
// One slot of the memory issue queue.
// A slot holds valid/op/data/label. It captures the CDB value for its pending
// operand (snoop), takes a bypassed CDB value when written, and is zeroed on
// clear. A write in the same cycle as a clear wins, so a full queue can
// refill the slot it is retiring.
import mem_issue_queue_pkg::*;

module mem_issue_queue_entry #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LABEL_W = LABEL_W_DEF
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               wr_en,
  input  logic               wr_op,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [LABEL_W-1:0] wr_label,
  input  logic               clr,
  input  logic               cdb_en,
  input  logic [LABEL_W-1:0] cdb_label,
  input  logic [DATA_W-1:0]  cdb_data,
  output logic               valid,
  output logic               op,
  output logic [DATA_W-1:0]  data,
  output logic [LABEL_W-1:0] label
);

  localparam logic [LABEL_W-1:0] LBL_NONE = LABEL_W'(LABEL_NONE);

  logic               valid_q, valid_d;
  logic               op_q, op_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic               snoop_hit;
  logic               bypass_hit;

  assign snoop_hit  = valid_q && (label_q != LBL_NONE) && cdb_en && (cdb_label == label_q);
  assign bypass_hit = cdb_en && (wr_label != LBL_NONE) && (cdb_label == wr_label);

  // Next slot contents: snoop, then clear, then write (write has last word).
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    label_d = label_q;
    if (snoop_hit) begin
      data_d  = cdb_data;
      label_d = LBL_NONE;
    end
    if (clr) begin
      valid_d = 1'b0;
      op_d    = 1'b0;
      data_d  = '0;
      label_d = LBL_NONE;
    end
    if (wr_en) begin
      valid_d = 1'b1;
      op_d    = wr_op;
      if (bypass_hit) begin
        data_d  = cdb_data;
        label_d = LBL_NONE;
      end else begin
        data_d  = wr_data;
        label_d = wr_label;
      end
    end
  end

  // Slot registers with asynchronous clear.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      op_q    <= 1'b0;
      data_q  <= '0;
      label_q <= LBL_NONE;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
      label_q <= label_d;
    end
  end

  assign valid = valid_q;
  assign op    = op_q;
  assign data  = data_q;
  assign label = label_q;

endmodule

// File: rtl/mem_issue_queue.sv
// In-order issue queue for memory ops (circular buffer, slots never move).
// The head issues once its operand is ready and retires on the memory unit's
// pop pulse. Each entry's tag is TAG_BASE + slot index.
// Optional: define MEM_QUEUE_FLUSH_EN to add a synchronous flush input.
import mem_issue_queue_pkg::*;

module mem_issue_queue #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LABEL_W  = LABEL_W_DEF,
  parameter int DEPTH    = 4,
  parameter int TAG_BASE = int'(QUE_TAG_BASE)
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic                       enq_op,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic [LABEL_W-1:0]         enq_label,
  output logic [LABEL_W-1:0]         enq_tag,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic                       issue_op,
  output logic [DATA_W-1:0]          issue_data,
  output logic [LABEL_W-1:0]         issue_tag,
  input  logic                       pop,
  input  logic                       cdb_en,
  input  logic [LABEL_W-1:0]         cdb_label,
  input  logic [DATA_W-1:0]          cdb_data,
`ifdef MEM_QUEUE_FLUSH_EN
  input  logic                       flush,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic               valid_w [DEPTH];
  logic               op_w    [DEPTH];
  logic [DATA_W-1:0]  data_w  [DEPTH];
  logic [LABEL_W-1:0] label_w [DEPTH];
  logic [DEPTH-1:0]   wr_sel;
  logic [DEPTH-1:0]   clr_sel;

  logic flush_w;
  logic pop_eff;
  logic enq_fire;
  logic head_present;

  // The memory unit latches the head itself; the queue only reacts to pop.
  logic unused_issue_ready;
  assign unused_issue_ready = issue_ready;

`ifdef MEM_QUEUE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign pop_eff   = pop && (count_q != '0);
  assign enq_ready = !flush_w && ((count_q < CNT_W'(DEPTH)) || pop_eff);
  assign enq_fire  = enq_valid && enq_ready;
  assign enq_tag   = LABEL_W'(TAG_BASE) + LABEL_W'(tail_q);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign wr_sel[gi]  = enq_fire && (tail_q == PTR_W'(gi));
      assign clr_sel[gi] = flush_w || (pop_eff && (head_q == PTR_W'(gi)));

      mem_issue_queue_entry #(
        .DATA_W  (DATA_W),
        .LABEL_W (LABEL_W)
      ) u_entry (
        .clk       (clk),
        .nRST      (nRST),
        .wr_en     (wr_sel[gi]),
        .wr_op     (enq_op),
        .wr_data   (enq_data),
        .wr_label  (enq_label),
        .clr       (clr_sel[gi]),
        .cdb_en    (cdb_en),
        .cdb_label (cdb_label),
        .cdb_data  (cdb_data),
        .valid     (valid_w[gi]),
        .op        (op_w[gi]),
        .data      (data_w[gi]),
        .label     (label_w[gi])
      );
    end
  endgenerate

  // Head mux: outputs are forced to zero when the head slot is empty.
  assign head_present = valid_w[head_q];
  assign issue_valid  = head_present && (label_w[head_q] == LABEL_W'(LABEL_NONE));
  assign issue_op     = head_present ? op_w[head_q] : 1'b0;
  assign issue_data   = head_present ? data_w[head_q] : '0;
  assign issue_tag    = head_present ? (LABEL_W'(TAG_BASE) + LABEL_W'(head_q)) : '0;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2**n).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_w) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      if (pop_eff)  head_d = head_q + PTR_W'(1);
      case ({enq_fire, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with asynchronous clear.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- Parametrised in-order issue queue for memory ops in the Tomasulo core; successor of the fixed 3-entry store queue.
- Circular buffer with head/tail pointers, replacing the shifting array; slots never move.
- Each entry snoops the CDB for its pending operand. The head entry issues to the memory unit once its operand is ready and is retired on the memory unit's last-state pulse.
- Entry tag = TAG_BASE + slot index, broadcast by memory on the CDB.

Parameters:
DATA_W, 32, operand/data width
LABEL_W, 4, rename label width; label 0 = operand ready
DEPTH, 4, entries; power of 2, >=2
TAG_BASE, 12, first queue tag; TAG_BASE != 0 and TAG_BASE+DEPTH-1 < 2**LABEL_W

Ports:
clk  in  1  clock
nRST  in  1  async active-low reset
enq_valid  in  1  dispatch requests a new entry (CU queue enable)
enq_ready  out  1  entry can be accepted this cycle
enq_op  in  1  1 = read, 0 = write
enq_data  in  DATA_W  operand value (valid when enq_label == 0)
enq_label  in  LABEL_W  producer label of operand, 0 = ready
enq_tag  out  LABEL_W  tag the new entry receives (TAG_BASE + tail)
issue_valid  out  1  head present and operand ready
issue_ready  in  1  memory unit available
issue_op  out  1  head op
issue_data  out  DATA_W  head operand
issue_tag  out  LABEL_W  head tag
pop  in  1  memory isLastState: retire head this edge
cdb_en  in  1  CDB broadcast valid
cdb_label  in  LABEL_W  CDB label
cdb_data  in  DATA_W  CDB value
count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (async, nRST low): all valid bits 0, head = tail = 0, count = 0. Every entry field = 0. issue_valid = 0, issue_op/data/tag = 0, enq_tag = TAG_BASE.
- Pop takes effect when pop && count>0. A pop on an empty queue is ignored (bench asserts it never happens).
- enq_ready = (count < DEPTH) || (pop && count > 0). Combinational from pop, so a full queue accepts in the same cycle it retires.
- Enqueue occurs when enq_valid && enq_ready. Slot[tail] is written with op, data and label, valid is set, and tail = tail+1 mod DEPTH.
- enq_tag = TAG_BASE + tail, combinational. It is meaningful only when enq_ready.
- CDB bypass on enqueue: if cdb_en && enq_label != 0 && cdb_label == enq_label, store cdb_data and label 0.
- Snoop: every valid entry with label != 0 and cdb_en && cdb_label == label loads cdb_data and clears its label at the same edge.
- Retire: valid[head] = 0 and head = head+1 mod DEPTH. Slot fields are zeroed.
- Simultaneous enqueue and pop: count unchanged. On a full queue tail == head, so the freed slot is rewritten with the new entry and valid stays 1; the new write has priority over the clear. The tag is reused immediately.
- issue_valid = valid[head] && label[head] == 0; purely combinational, with no internal state machine. issue_ready is informational only: the memory unit latches the head itself, and the queue changes only on pop. Head outputs are 0 when the queue is empty.
- Queue state is held as registered head, tail and count. Pointer wrap-around is natural modulo DEPTH.
- Latency:
  - Enqueue with ready operand: issue_valid the next cycle when the queue was empty.
  - Operand arriving by CDB: issue_valid the cycle after the broadcast.
- Ordering: strictly FIFO. Retirement order equals enqueue order.

Optional Feature:
- MEM_QUEUE_FLUSH_EN: adds input port flush (1 bit).
- When flush = 1 at an edge, all valid bits, head, tail and count are cleared, exactly as reset but synchronous. Flush has priority over enqueue, pop and snoop, and enq_ready = 0 while flush = 1.
- Without the macro the port does not exist and there is no flush logic.

Decomposition:
- Shared package (head.v): LABEL_NONE = 0, default DATA_W/LABEL_W, QUE_TAG_BASE = 4'b1100, op encodings READ = 1 / WRITE = 0.
- One sub-module, mem_issue_queue_entry: a single slot holding valid/op/data/label, with write, snoop, bypass and clear logic.
- The top level generates DEPTH entries plus the pointer/count logic and the head mux.

Test Plan:
- Reset, then enqueue op=0, data=0x100, label=0 → next cycle issue_valid=1, issue_data=0x100, issue_tag=12, count=1.
- Enqueue label=5, data=x, then cdb_en=1, label=5, data=0xABCD → next cycle issue_valid=1, issue_data=0xABCD; a second entry with label=5 enqueued in the broadcast cycle captures 0xABCD by bypass.
- Fill 4 entries, tags 12,13,14,15 → enq_ready=0, count=4. Assert pop with enq_valid → enq_ready=1, new entry gets tag 12, count stays 4.
- Enqueue/pop 10 times across wrap → issued data order matches enqueue order and tags cycle 12..15.
- Assert nRST mid-operation with 3 entries → immediately count=0, issue_valid=0, enq_tag=12.
- With MEM_QUEUE_FLUSH_EN: flush with 2 entries plus simultaneous enq_valid → next cycle count=0 and nothing enqueued.
